wb_gpio_responder: RTL
======================

Name: wb_gpio_responder

Overview:
- Wishbone classic responder that puts the user GPIO bank under management-SoC control.
- Holds output-data, output-enable and interrupt registers, and drives io_out and io_oeb from them.
- Synchronises io_in and raises user_irq[0] on enabled rising edges.
- Instantiated inside user_proj_example, on the wbs_* bus and the 16-bit io bank.

Parameters:
- BASE_ADDR, 32'h3000_0000, decode base; a request matches when wbs_adr_i[31:8] == BASE_ADDR[31:8].
- NGPIO, 16, GPIO width, 1..32.
- SYNC_STAGES, 2, number of io_in synchroniser flops, minimum 2.

Ports:
- wb_clk_i  input  1  sole clock.
- wb_rst_i  input  1  synchronous, active-low reset.
- wbs_cyc_i  input  1  bus cycle.
- wbs_stb_i  input  1  strobe.
- wbs_we_i  input  1  1 = write.
- wbs_sel_i  input  4  byte lane enables.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  single-cycle acknowledge.
- wbs_dat_o  output  32  read data.
- io_in  input  NGPIO  pad inputs, asynchronous.
- io_out  output  NGPIO  pad output data.
- io_oeb  output  NGPIO  pad output enable, active-low.
- user_irq  output  3  [0] = GPIO interrupt; [2:1] tied 0.

Behaviour:
- Register map, word offsets decoded on wbs_adr_i[7:2]:
  - 0x00 OUT, RW.
  - 0x04 OE, RW; 1 = drive; io_oeb = ~OE.
  - 0x08 IN, RO; synchronised io_in.
  - 0x0C IRQ_EN, RW.
  - 0x10 IRQ_STAT, W1C.
  - 0x14 ID, RO, 32'h4750_494F.
  - Bits at or above NGPIO read 0 and ignore writes.
  - Unmapped offsets read 0, ignore writes and are still acked.
- FSM, two states:
  - IDLE: a request is cyc & stb & address match. On a request, go to ACK; non-matching requests are ignored (no ack).
  - ACK: wbs_ack_o = 1 for exactly this one cycle, then IDLE unconditionally.
  - A request is never accepted in ACK, so the minimum spacing between acks is 2 cycles.
  - Latency from request to ack is 1 cycle.
- Writes:
  - Committed on the clock edge that enters ACK.
  - Byte lane k updates bits [8k+7:8k] only when wbs_sel_i[k] = 1.
  - IRQ_STAT bit cleared when the written bit is 1 and its lane is selected.
- Reads:
  - wbs_dat_o is registered on the edge entering ACK and valid while ack = 1.
  - wbs_dat_o = 0 whenever ack = 0.
- io_out and io_oeb are driven directly from the OUT and OE registers; a new value appears the cycle ack is high.
- Input synchroniser: io_in reaches IN after SYNC_STAGES cycles.
- Edge detection:
  - prev register holds the last IN value.
  - Rising edge on bit i (IN & ~prev) sets IRQ_STAT[i] one cycle after IN changes.
  - IRQ_STAT latches regardless of IRQ_EN.
- Arming: after reset deassertion, an arm counter suppresses edge detection for SYNC_STAGES+1 cycles. An input already high through reset therefore raises no interrupt.
- Interrupt output:
  - user_irq[0] is registered as |(IRQ_STAT & IRQ_EN), so it is 1 cycle after the STAT bit sets or clears.
  - Total latency from an io_in edge to user_irq[0] is SYNC_STAGES+2 cycles.
- Simultaneous edge-set and W1C-clear on the same bit: set wins and the bit stays 1.
- Reset (wb_rst_i = 0 at an edge):
  - FSM to IDLE; ack 0; wbs_dat_o 0.
  - OUT, OE, IRQ_EN, IRQ_STAT, sync and prev registers all 0; io_out 0; io_oeb all 1.
  - user_irq 0; arm counter restarts.
  - Reset takes priority over a concurrent write: nothing commits.
  - Reset in the ACK state drops ack at that edge.
- The master dropping cyc or stb while in ACK still completes the ack cycle, with the write already committed; this is benign and the bench does not flag it.

Test Plan:
- Reset, then read ID at 0x3000_0014 -> ack exactly 1 cycle after stb; dat = 32'h4750_494F; io_oeb = 16'hFFFF; io_out = 0; user_irq = 0.
- Write OE = 16'h00FF with sel = 4'b0001, then OUT = 16'hA5A5 with sel = 4'b0011 -> OE reads 16'h00FF, io_oeb = 16'hFF00; io_out = 16'hA5A5. A subsequent OUT write of 32'h0000_1234 with sel = 4'b0010 -> io_out = 16'h12A5.
- Access at 0x3000_0100 (address mismatch) -> no ack for 10 cycles; write to 0x3000_0020 (unmapped) -> ack, read returns 0, no register changes.
- IRQ_EN = 1, then raise io_in[0] -> IN[0] after 2 cycles; IRQ_STAT[0] = 1 after 3; user_irq[0] = 1 after 4. Writing IRQ_STAT = 1 clears it, and user_irq[0] drops 1 cycle after the ack.
- W1C of bit 3 issued on the same edge that a rising edge on io_in[3] is detected -> IRQ_STAT[3] stays 1.
- Hold io_in = 16'hFFFF through reset and for 10 cycles after -> IRQ_STAT = 0. Separately, assert reset during the ACK cycle of a write of OUT = 16'h00FF -> ack drops and OUT stays 0.

Source files
------------

// File: rtl/wb_gpio_responder.sv
// Wishbone classic responder exposing a GPIO bank to the management SoC.
// Holds OUT / OE / IRQ_EN / IRQ_STAT registers, synchronises the pad
// inputs, and raises user_irq[0] when an enabled rising edge is latched.
module wb_gpio_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NGPIO       = 16,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NGPIO-1:0] io_in,
    output logic [NGPIO-1:0] io_out,
    output logic [NGPIO-1:0] io_oeb,
    output logic [2:0]       user_irq
);

    localparam logic [5:0]  OFF_OUT  = 6'h00;
    localparam logic [5:0]  OFF_OE   = 6'h01;
    localparam logic [5:0]  OFF_IN   = 6'h02;
    localparam logic [5:0]  OFF_EN   = 6'h03;
    localparam logic [5:0]  OFF_STAT = 6'h04;
    localparam logic [5:0]  OFF_ID   = 6'h05;
    localparam logic [31:0] ID_VALUE = 32'h4750_494F;

    // The arm counter must be able to hold SYNC_STAGES+1.
    localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    // Expands the four byte-lane enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    state_e            state_q, state_d;
    logic [NGPIO-1:0]  out_q, out_d;
    logic [NGPIO-1:0]  oe_q, oe_d;
    logic [NGPIO-1:0]  en_q, en_d;
    logic [NGPIO-1:0]  stat_q, stat_d;
    logic [NGPIO-1:0]  prev_q, prev_d;
    logic [NGPIO-1:0]  sync_q [SYNC_STAGES];
    logic [NGPIO-1:0]  sync_d [SYNC_STAGES];
    logic [ARM_W-1:0]  arm_q, arm_d;
    logic              irq_q, irq_d;
    logic [31:0]       dat_q, dat_d;

    logic              req_s;
    logic              accept_s;
    logic              wr_s;
    logic              armed_s;
    logic              ack_s;
    logic [5:0]        off_s;
    logic [31:0]       mask_s;
    logic [NGPIO-1:0]  wmask_s;
    logic [NGPIO-1:0]  wdat_s;
    logic [NGPIO-1:0]  in_s;
    logic [NGPIO-1:0]  rise_s;
    logic [NGPIO-1:0]  clr_s;
    logic [31:0]       rdata_s;
    logic              unused_s;

    // Address decode and bus handshake qualification.
    always_comb begin
        req_s    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        accept_s = req_s & (state_q == ST_IDLE);
        wr_s     = accept_s & wbs_we_i;
        off_s    = wbs_adr_i[7:2];
        mask_s   = lane_mask(wbs_sel_i);
        wmask_s  = mask_s[NGPIO-1:0];
        wdat_s   = wbs_dat_i[NGPIO-1:0];
        in_s     = sync_q[SYNC_STAGES-1];
        armed_s  = (arm_q == ARM_DONE);
    end

    // Byte-lane address bits and lanes above NGPIO carry no information here.
    assign unused_s = ^{wbs_adr_i[1:0], mask_s, wbs_dat_i};

    // FSM next state: a request in IDLE earns exactly one ACK cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode: acknowledge while in the ACK state.
    always_comb begin
        ack_s = 1'b0;
        case (state_q)
            ST_ACK:  ack_s = 1'b1;
            ST_IDLE: ack_s = 1'b0;
            default: ack_s = 1'b0;
        endcase
    end

    // Writable registers: byte-lane merge on the edge that enters ACK.
    always_comb begin
        out_d = out_q;
        oe_d  = oe_q;
        en_d  = en_q;
        if (wr_s) begin
            case (off_s)
                OFF_OUT: out_d = (out_q & ~wmask_s) | (wdat_s & wmask_s);
                OFF_OE:  oe_d  = (oe_q  & ~wmask_s) | (wdat_s & wmask_s);
                OFF_EN:  en_d  = (en_q  & ~wmask_s) | (wdat_s & wmask_s);
                default: begin
                    out_d = out_q;
                    oe_d  = oe_q;
                    en_d  = en_q;
                end
            endcase
        end else begin
            out_d = out_q;
            oe_d  = oe_q;
            en_d  = en_q;
        end
    end

    // Edge detection and IRQ_STAT update; a same-cycle set beats a W1C clear.
    always_comb begin
        clr_s = {NGPIO{1'b0}};
        if (wr_s && (off_s == OFF_STAT)) begin
            clr_s = wdat_s & wmask_s;
        end else begin
            clr_s = {NGPIO{1'b0}};
        end
        if (armed_s) begin
            rise_s = in_s & ~prev_q;
            arm_d  = arm_q;
        end else begin
            rise_s = {NGPIO{1'b0}};
            arm_d  = arm_q + ARM_W'(1);
        end
        stat_d = (stat_q & ~clr_s) | rise_s;
        prev_d = in_s;
        irq_d  = |(stat_q & en_q);
    end

    // Input synchroniser shift chain.
    always_comb begin
        sync_d[0] = io_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Read-data mux; registered only for an accepted read, zero otherwise.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (off_s)
            OFF_OUT:  rdata_s[NGPIO-1:0] = out_q;
            OFF_OE:   rdata_s[NGPIO-1:0] = oe_q;
            OFF_IN:   rdata_s[NGPIO-1:0] = in_s;
            OFF_EN:   rdata_s[NGPIO-1:0] = en_q;
            OFF_STAT: rdata_s[NGPIO-1:0] = stat_q;
            OFF_ID:   rdata_s            = ID_VALUE;
            default:  rdata_s            = 32'h0000_0000;
        endcase
        if (accept_s && !wbs_we_i) begin
            dat_d = rdata_s;
        end else begin
            dat_d = 32'h0000_0000;
        end
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
            out_q   <= {NGPIO{1'b0}};
            oe_q    <= {NGPIO{1'b0}};
            en_q    <= {NGPIO{1'b0}};
            stat_q  <= {NGPIO{1'b0}};
            prev_q  <= {NGPIO{1'b0}};
            arm_q   <= {ARM_W{1'b0}};
            irq_q   <= 1'b0;
            dat_q   <= 32'h0000_0000;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= {NGPIO{1'b0}};
            end
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            en_q    <= en_d;
            stat_q  <= stat_d;
            prev_q  <= prev_d;
            arm_q   <= arm_d;
            irq_q   <= irq_d;
            dat_q   <= dat_d;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign wbs_ack_o = ack_s;
    assign wbs_dat_o = dat_q;
    assign io_out    = out_q;
    assign io_oeb    = ~oe_q;
    assign user_irq  = {2'b00, irq_q};

endmodule
